// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg
//   Shared definitions for the multiplier / product-accumulator datapath.
//   - default operand, guard and counter widths used by both the multiplier
//     wrapper and the accumulator
//   - derived product and accumulator widths
//   - accumulator sequencer state encoding
package mul_acc_pkg;

  localparam int N_DEF     = 32;
  localparam int G_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  localparam int PROD_W = 2 * N_DEF;
  localparam int ACC_W  = PROD_W + G_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/acc_adder_reg.sv
// acc_adder_reg
//   Registered unsigned accumulator with a sticky carry flag.
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous active-high reset, clears sum and carry
//     clr    : synchronous clear of sum and carry (start of a job)
//     en     : add addend into the sum this cycle
//     addend : unsigned IN_W-bit value, zero-extended to W bits
//     acc    : registered W-bit sum, wraps modulo 2^W
//     carry  : sticky carry out of bit W-1 since the last clear
module acc_adder_reg #(
  parameter int W    = 72,
  parameter int IN_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [IN_W-1:0] addend,
  output logic [W-1:0]    acc,
  output logic            carry
);

  // Wrapping unsigned add; bit W of the result is the carry out.
  function automatic logic [W:0] add_wrap(input logic [W-1:0] a,
                                          input logic [IN_W-1:0] b);
    return {1'b0, a} + {{(W + 1 - IN_W){1'b0}}, b};
  endfunction

  logic [W:0]   sum_p0;
  logic [W-1:0] acc_p1;
  logic         carry_p1;

  // Stage 0: combinational add of the current sum and the incoming addend
  assign sum_p0 = add_wrap(acc_p1, addend);

  // Stage 1: registered sum and sticky carry
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_p1   <= '0;
      carry_p1 <= 1'b0;
    end else if (en) begin
      acc_p1   <= sum_p0[W-1:0];
      carry_p1 <= carry_p1 | sum_p0[W];
    end
  end

  assign acc   = acc_p1;
  assign carry = carry_p1;

endmodule

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
//   Sums a programmed number of 2N-bit unsigned products into a (2N+G)-bit
//   accumulator, with valid/ready handshakes on input and output.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     start      : begins a job (honoured only when idle)
//     length     : number of products in the job, sampled with start
//     in_valid   : product word valid
//     in_ready   : a product is accepted this cycle when in_valid is high
//     product    : unsigned 2N-bit product
//     acc_out    : accumulator value, meaningful while out_valid is high
//     out_valid  : job complete, acc_out stable
//     out_ready  : consumer takes the result
//     overflow   : sticky carry out of the accumulator MSB in this job
//     busy       : high while accumulating or holding a result
//     count      : products accepted in the current job
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int G     = G_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     length,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*N-1:0]       product,
  output logic [2*N+G-1:0]     acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 busy,
  output logic [CNT_W-1:0]     count
);

  localparam int PROD_BITS = 2 * N;
  localparam int ACC_BITS  = 2 * N + G;

  acc_state_t       state_q;
  acc_state_t       state_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] remaining_q;
  logic             job_clr;
  logic             vld_p0;

  // Stage 0: handshake decode and next-state logic
  assign vld_p0  = (state_q == ST_ACCUM) && in_valid;
  assign job_clr = (state_q == ST_IDLE) && start;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (length != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (vld_p0 && (remaining_q == CNT_W'(1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage 1: control registers and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (job_clr) begin
        count_q     <= '0;
        remaining_q <= length;
      end else if (vld_p0) begin
        count_q     <= count_q + CNT_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

  acc_adder_reg #(
    .W    (ACC_BITS),
    .IN_W (PROD_BITS)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (job_clr),
    .en     (vld_p0),
    .addend (product),
    .acc    (acc_out),
    .carry  (overflow)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign count     = count_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
module tb_mul_product_accumulator;

  logic         clk;
  logic         reset;
  logic         start;
  logic [15:0]  length;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  product;
  logic [71:0]  acc_out;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         busy;
  logic [15:0]  count;

  int tests_run;
  int tests_failed;

  mul_product_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  task automatic xfer(input logic [63:0] p);
    in_valid = 1'b1;
    product  = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"},  in_ready,  0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".overflow"},  overflow,  0);
    check({tag, ".acc_out"},   acc_out,   0);
    check({tag, ".count"},     count,     0);
  endtask

  logic [71:0] held_acc;
  int          exp_cnt;
  logic [6:0]  gap_pat;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    start     = 1'b0;
    length    = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");

    // reset mid-job after 2 of 5 products
    reset = 1'b0;
    do_start(16'd5);
    check("midrst.in_ready", in_ready, 1);
    xfer(64'd3);
    xfer(64'd3);
    check("midrst.count2", count, 2);
    check("midrst.acc2", acc_out, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midrst.after");
    do_start(16'd1);
    xfer(64'd7);
    check("len1.out_valid", out_valid, 1);
    check("len1.acc", acc_out, 7);
    check("len1.count", count, 1);
    release_result();
    check("len1.idle_valid", out_valid, 0);
    check("len1.acc_kept", acc_out, 7);

    // back-to-back products
    do_start(16'd3);
    check("b2b.acc_cleared", acc_out, 0);
    xfer(64'd6);
    check("b2b.acc1", acc_out, 6);
    check("b2b.valid1", out_valid, 0);
    xfer(64'd12);
    check("b2b.valid2", out_valid, 0);
    xfer(64'hFFFF_FFFF_0000_0001);
    check("b2b.out_valid", out_valid, 1);
    check("b2b.in_ready", in_ready, 0);
    check("b2b.acc", acc_out, 72'h00_FFFF_FFFF_0000_0013);
    check("b2b.count", count, 3);
    check("b2b.overflow", overflow, 0);
    release_result();

    // gapped in_valid 1,0,0,1,1,0,1 with product 5
    do_start(16'd4);
    gap_pat = 7'b1011001;
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_pat[i];
      product  = 64'd5;
      tick();
      if (gap_pat[i]) exp_cnt++;
      check($sformatf("gap.count%0d", i), count, exp_cnt);
      check($sformatf("gap.acc%0d", i), acc_out, 5 * exp_cnt);
      check($sformatf("gap.valid%0d", i), out_valid, (exp_cnt == 4) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("gap.acc_final", acc_out, 20);
    release_result();

    // zero-length job
    check("len0.pre_ready", in_ready, 0);
    do_start(16'd0);
    check("len0.out_valid", out_valid, 1);
    check("len0.in_ready", in_ready, 0);
    check("len0.acc", acc_out, 0);
    check("len0.count", count, 0);
    check("len0.busy", busy, 1);
    release_result();
    check("len0.busy_after", busy, 0);

    // 257 maximal products: wraps the 72-bit accumulator
    do_start(16'd257);
    for (int i = 0; i < 256; i++) begin
      xfer(64'hFFFF_FFFF_FFFF_FFFF);
    end
    check("ovf.not_yet", overflow, 0);
    check("ovf.acc256", acc_out, 72'hFF_FFFF_FFFF_FFFF_FF00);
    check("ovf.valid256", out_valid, 0);
    xfer(64'hFFFF_FFFF_FFFF_FFFF);
    check("ovf.flag", overflow, 1);
    check("ovf.acc", acc_out, 72'h00_FFFF_FFFF_FFFF_FEFF);
    check("ovf.count", count, 257);
    check("ovf.out_valid", out_valid, 1);

    // DONE hold with start pulses and out_ready low
    held_acc = acc_out;
    for (int i = 0; i < 3; i++) begin
      start  = 1'b1;
      length = 16'd9;
      tick();
      start  = 1'b0;
      check($sformatf("hold.valid%0d", i), out_valid, 1);
      check($sformatf("hold.acc%0d", i), acc_out, held_acc);
      check($sformatf("hold.count%0d", i), count, 257);
      check($sformatf("hold.ovf%0d", i), overflow, 1);
      check($sformatf("hold.in_ready%0d", i), in_ready, 0);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("exit.out_valid", out_valid, 0);
    check("exit.busy", busy, 0);
    check("exit.in_ready", in_ready, 0);
    check("exit.acc_kept", acc_out, held_acc);
    do_start(16'd2);
    check("restart.in_ready", in_ready, 1);
    check("restart.busy", busy, 1);
    check("restart.acc", acc_out, 0);
    check("restart.count", count, 0);
    check("restart.ovf", overflow, 0);
    xfer(64'd10);
    xfer(64'd20);
    check("restart.result", acc_out, 30);
    check("restart.valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
